// File: rtl/csa_final_adder_pkg.sv
// csa_final_adder_pkg: shared widths for the carry-save final adder
package csa_final_adder_pkg;
  localparam int CSA_N = 32;
  localparam int RES_W = CSA_N + 2;
  localparam int HALF_W = CSA_N / 2;
  function automatic int res_w(input int n);
    return n + 2;
  endfunction
  function automatic int half_w(input int n);
    return n / 2;
  endfunction
endpackage

// File: rtl/csa_final_adder_if.sv
// csa_final_adder_if: carry-save input stream and resolved-sum output stream
interface csa_final_adder_if import csa_final_adder_pkg::*; #(parameter int n = CSA_N);
  logic in_valid;
  logic in_ready;
  logic [n-1:0] in_s;
  logic [n-1:0] in_c;
  logic in_cout;
  logic out_valid;
  logic out_ready;
  logic [n+1:0] out_sum;
  modport master (output in_valid, in_s, in_c, in_cout, out_ready, input in_ready, out_valid, out_sum);
  modport slave (input in_valid, in_s, in_c, in_cout, out_ready, output in_ready, out_valid, out_sum);
endinterface

// File: rtl/csa_final_adder_half_add.sv
// csa_half_add: w-bit combinational adder with carry in and carry out
module csa_half_add #(parameter int w = 16) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  input  logic         ci,
  output logic [w-1:0] sum,
  output logic         co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{w{1'b0}}, ci};
endmodule

// File: rtl/csa_final_adder.sv
// csa_final_adder: two-stage pipelined resolution of a carry-save word into binary
module csa_final_adder import csa_final_adder_pkg::*; #(parameter int n = CSA_N) (
  input logic clk,
  input logic rst,
  csa_final_adder_if.slave bus
);
  localparam int HW = half_w(n);
  localparam int RW = res_w(n);
  logic v1_q, v1_d, v2_q, v2_d, co_q, co_d;
  logic [HW-1:0] lo_q, lo_d, lo_sum;
  logic [HW:0] ahi_q, ahi_d, bhi_q, bhi_d, hi_sum;
  logic [RW-1:0] sum_q, sum_d;
  logic lo_co, hi_co, drain, adv1, ready, acc;
  csa_half_add #(.w(HW)) u_lo (
    .a(bus.in_s[HW-1:0]), .b({bus.in_c[HW-2:0], 1'b0}), .ci(1'b0), .sum(lo_sum), .co(lo_co)
  );
  csa_half_add #(.w(HW + 1)) u_hi (
    .a(ahi_q), .b(bhi_q), .ci(co_q), .sum(hi_sum), .co(hi_co)
  );
  // c[n-1] and cout both land on weight 2^n, so they extend the upper slices by one column
  always_comb begin
    drain = v2_q && bus.out_ready;
    adv1 = v1_q && (!v2_q || bus.out_ready);
    ready = !rst && (!v1_q || adv1);
    acc = bus.in_valid && ready;
    v1_d = acc || (v1_q && !adv1);
    v2_d = adv1 || (v2_q && !drain);
    lo_d = acc ? lo_sum : lo_q;
    co_d = acc ? lo_co : co_q;
    ahi_d = acc ? {bus.in_c[n-1], bus.in_s[n-1:HW]} : ahi_q;
    bhi_d = acc ? {bus.in_cout, bus.in_c[n-2:HW-1]} : bhi_q;
    sum_d = adv1 ? {hi_co, hi_sum, lo_q} : sum_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      co_q <= 1'b0;
      lo_q <= '0;
      ahi_q <= '0;
      bhi_q <= '0;
      sum_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      co_q <= co_d;
      lo_q <= lo_d;
      ahi_q <= ahi_d;
      bhi_q <= bhi_d;
      sum_q <= sum_d;
    end
  end
  assign bus.in_ready = ready;
  assign bus.out_valid = v2_q;
  assign bus.out_sum = sum_q;
endmodule
